// File: rtl/taxi_state_ctrl.sv
// Taxi meter trip controller: tracks IDLE/MOVE/WAIT from debounced buttons,
// accumulates moving and waiting seconds per trip, and forces a trip to end
// when a single waiting stop lasts MAX_WAIT seconds.
module taxi_state_ctrl #(
  parameter int MAX_WAIT = 300,
  parameter int MAX_CNT  = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_wait,
  input  logic       btn_stop,
  input  logic       tick_sec,
  output logic [1:0] state,
  output logic [9:0] move_sec,
  output logic [9:0] wait_sec,
  output logic       trip_done
);

  localparam int TW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [9:0]    CNT_MAX = 10'(MAX_CNT);
  localparam logic [TW-1:0] TMR_MAX = TW'(MAX_WAIT);

  // 2'b10 is never entered on purpose; it only recovers to IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MOVE = 2'b01,
    S_BAD  = 2'b10,
    S_WAIT = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    move_q, move_d;
  logic [9:0]    wait_q, wait_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          done_q, done_d;
  logic          start_hist_q, wait_hist_q, stop_hist_q;

  logic          ev_start, ev_wait, ev_stop;
  logic [TW-1:0] tmr_inc;
  logic          timeout;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 10'd1;
  endfunction

  assign ev_start = btn_start & ~start_hist_q;
  assign ev_wait  = btn_wait  & ~wait_hist_q;
  assign ev_stop  = btn_stop  & ~stop_hist_q;
  assign tmr_inc  = tmr_q + TW'(1);
  assign timeout  = tick_sec && (tmr_inc == TMR_MAX);

  // Button history starts at 1 so a button held through reset never fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_hist_q <= 1'b1;
      wait_hist_q  <= 1'b1;
      stop_hist_q  <= 1'b1;
    end else begin
      start_hist_q <= btn_start;
      wait_hist_q  <= btn_wait;
      stop_hist_q  <= btn_stop;
    end
  end

  // Register the trip state, counters, wait timer and end-of-trip pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      move_q  <= 10'd0;
      wait_q  <= 10'd0;
      tmr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      move_q  <= move_d;
      wait_q  <= wait_d;
      tmr_q   <= tmr_d;
      done_q  <= done_d;
    end
  end

  // Next state: ticks credit the current state, then stop > wait > start,
  // with the wait timeout overriding any button in WAIT.
  always_comb begin
    state_d = state_q;
    move_d  = move_q;
    wait_d  = wait_q;
    tmr_d   = tmr_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ev_start) begin
          state_d = S_MOVE;
          move_d  = 10'd0;
          wait_d  = 10'd0;
        end
      end
      S_MOVE: begin
        if (tick_sec) move_d = sat_inc(move_q);
        if (ev_stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (ev_wait) begin
          state_d = S_WAIT;
          tmr_d   = '0;
        end
      end
      S_WAIT: begin
        if (tick_sec) begin
          wait_d = sat_inc(wait_q);
          tmr_d  = tmr_inc;
        end
        if (timeout || ev_stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (ev_start) begin
          state_d = S_MOVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state     = state_q;
  assign move_sec  = move_q;
  assign wait_sec  = wait_q;
  assign trip_done = done_q;

endmodule
